// File: rtl/fifo_pkt_reader.sv
// Pop-side FIFO consumer: accumulates per-packet length/sum/error using the
// word MSB as end-of-packet, and presents one registered summary per packet.
module fifo_pkt_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH:0]   fifo_data_i,
  input  logic                  fifo_valid_i,
  output logic                  fifo_grant_o,
  output logic                  pkt_valid_o,
  input  logic                  pkt_ready_i,
  output logic [LEN_W-1:0]      pkt_len_o,
  output logic [DATA_WIDTH-1:0] pkt_sum_o,
  output logic                  pkt_err_o,
  output logic [15:0]           pkt_cnt_o
);

  typedef enum logic {RECV, HOLD} state_e;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic [LEN_W-1:0]      out_len_q, out_len_d;
  logic [DATA_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                  out_err_q, out_err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  xfer;
  logic                  last;
  logic [LEN_W-1:0]      acc_len;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic                  acc_err;

  // Grant depends only on registered state, never on fifo_valid_i.
  assign fifo_grant_o = (state_q == RECV) && enable_i && !rst;
  assign xfer         = fifo_valid_i && fifo_grant_o;
  assign last         = fifo_data_i[DATA_WIDTH];

  // Accumulator values including the word being transferred this cycle.
  always_comb begin
    acc_sum = sum_q + fifo_data_i[DATA_WIDTH-1:0];
    acc_len = len_q;
    acc_err = err_q;
    if (len_q < MAX_LEN_C) begin
      acc_len = len_q + LEN_W'(1);
    end else begin
      acc_err = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    err_d     = err_q;
    valid_d   = valid_q;
    out_len_d = out_len_q;
    out_sum_d = out_sum_q;
    out_err_d = out_err_q;
    cnt_d     = cnt_q;
    case (state_q)
      RECV: begin
        if (xfer) begin
          if (last) begin
            out_len_d = acc_len;
            out_sum_d = acc_sum;
            out_err_d = acc_err;
            valid_d   = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            len_d     = '0;
            sum_d     = '0;
            err_d     = 1'b0;
            state_d   = HOLD;
          end else begin
            len_d = acc_len;
            sum_d = acc_sum;
            err_d = acc_err;
          end
        end
      end
      HOLD: begin
        if (valid_q && pkt_ready_i) begin
          valid_d = 1'b0;
          state_d = RECV;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RECV;
      len_q     <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      out_len_q <= '0;
      out_sum_q <= '0;
      out_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      out_len_q <= out_len_d;
      out_sum_q <= out_sum_d;
      out_err_q <= out_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pkt_valid_o = valid_q;
  assign pkt_len_o   = out_len_q;
  assign pkt_sum_o   = out_sum_q;
  assign pkt_err_o   = out_err_q;
  assign pkt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed self-checking bench for fifo_pkt_reader (DATA_WIDTH=8, MAX_LEN=4)
// with a queue standing in for the upstream FIFO.
module tb_fifo_pkt_reader;

  localparam int DW    = 8;
  localparam int ML    = 4;
  localparam int LW    = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_i;
  logic [DW:0]   fifo_data_i;
  logic          fifo_valid_i;
  logic          fifo_grant_o;
  logic          pkt_valid_o;
  logic          pkt_ready_i;
  logic [LW-1:0] pkt_len_o;
  logic [DW-1:0] pkt_sum_o;
  logic          pkt_err_o;
  logic [15:0]   pkt_cnt_o;

  logic [DW:0]   fifo_q[$];
  int unsigned   pops;
  logic          grant_seen;
  logic          xfer;
  int unsigned   n_tests;
  int unsigned   n_fail;
  int unsigned   pops_mark;
  logic [DW-1:0] sum_mark;

  fifo_pkt_reader #(
    .DATA_WIDTH(DW),
    .MAX_LEN   (ML)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .fifo_data_i (fifo_data_i),
    .fifo_valid_i(fifo_valid_i),
    .fifo_grant_o(fifo_grant_o),
    .pkt_valid_o (pkt_valid_o),
    .pkt_ready_i (pkt_ready_i),
    .pkt_len_o   (pkt_len_o),
    .pkt_sum_o   (pkt_sum_o),
    .pkt_err_o   (pkt_err_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: present FIFO head, note grant/transfer, pop on transfer.
  task automatic tick();
    fifo_valid_i = (fifo_q.size() != 0);
    fifo_data_i  = fifo_valid_i ? fifo_q[0] : '0;
    #1;
    grant_seen = fifo_grant_o;
    xfer       = fifo_valid_i && fifo_grant_o;
    @(posedge clk);
    if (xfer) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    @(negedge clk);
  endtask

  task automatic wait_pkt(input string tag);
    int unsigned n;
    n = 0;
    while (!pkt_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!pkt_valid_o) check({tag, "_timeout"}, 32'(pkt_valid_o), 32'd1);
  endtask

  task automatic check_sum(input string tag, input int unsigned len, input int unsigned sum,
                           input int unsigned err, input int unsigned cnt);
    check({tag, "_valid"}, 32'(pkt_valid_o), 32'd1);
    check({tag, "_len"},   32'(pkt_len_o),   32'(len));
    check({tag, "_sum"},   32'(pkt_sum_o),   32'(sum));
    check({tag, "_err"},   32'(pkt_err_o),   32'(err));
    check({tag, "_cnt"},   32'(pkt_cnt_o),   32'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    pops         = 0;
    rst          = 1'b1;
    enable_i     = 1'b1;
    pkt_ready_i  = 1'b1;
    fifo_valid_i = 1'b0;
    fifo_data_i  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(pkt_valid_o), 32'd0);
    check("rst_len",   32'(pkt_len_o),   32'd0);
    check("rst_sum",   32'(pkt_sum_o),   32'd0);
    check("rst_err",   32'(pkt_err_o),   32'd0);
    check("rst_cnt",   32'(pkt_cnt_o),   32'd0);
    check("rst_grant", 32'(fifo_grant_o), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_grant", 32'(fifo_grant_o), 32'd1);

    // Three-word packet, exact latency and single HOLD cycle
    fifo_q.push_back(9'h010);
    fifo_q.push_back(9'h020);
    fifo_q.push_back(9'h130);
    tick();
    tick();
    check("p1_no_valid_yet", 32'(pkt_valid_o), 32'd0);
    tick();
    check_sum("p1", 3, 8'h60, 0, 1);
    check("p1_grant_hold", 32'(fifo_grant_o), 32'd0);
    check("p1_pops", pops, 32'd3);
    tick();
    check("p1_accepted", 32'(pkt_valid_o), 32'd0);
    check("p1_grant_back", 32'(fifo_grant_o), 32'd1);
    check("p1_len_kept", 32'(pkt_len_o), 32'd3);

    // Single-word packet, then a wrapping sum; second packet queued during HOLD
    fifo_q.push_back(9'h1FF);
    tick();
    check_sum("p2", 1, 8'hFF, 0, 2);
    fifo_q.push_back(9'h0FF);
    fifo_q.push_back(9'h102);
    tick();
    check("p2_no_pop_in_hold", pops, 32'd4);
    tick();
    tick();
    check_sum("p3", 2, 8'h01, 0, 3);
    tick();

    // Over-length packet: 6 words, all popped, len saturates, err set
    pops_mark = pops;
    for (int i = 1; i <= 5; i++) fifo_q.push_back(9'(i));
    fifo_q.push_back(9'h106);
    wait_pkt("p4");
    check_sum("p4", 4, 8'h15, 1, 4);
    check("p4_pops", pops - pops_mark, 32'd6);
    tick();
    fifo_q.push_back(9'h105);
    wait_pkt("p5");
    check_sum("p5", 1, 8'h05, 0, 5);
    tick();

    // Exactly MAX_LEN words: no error
    fifo_q.push_back(9'h001);
    fifo_q.push_back(9'h001);
    fifo_q.push_back(9'h001);
    fifo_q.push_back(9'h101);
    wait_pkt("p6");
    check_sum("p6", 4, 8'h04, 0, 6);
    tick();

    // Downstream backpressure with the FIFO non-empty
    pkt_ready_i = 1'b0;
    fifo_q.push_back(9'h00A);
    fifo_q.push_back(9'h10B);
    fifo_q.push_back(9'h00C);
    fifo_q.push_back(9'h10D);
    wait_pkt("p7");
    check_sum("p7", 2, 8'h15, 0, 7);
    pops_mark = pops;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("p7_hold_grant", 32'(grant_seen), 32'd0);
      check("p7_hold_valid", 32'(pkt_valid_o), 32'd1);
      check("p7_hold_sum", 32'(pkt_sum_o), 32'h15);
    end
    check("p7_hold_pops", pops - pops_mark, 32'd0);
    pkt_ready_i = 1'b1;
    tick();
    check("p7_accepted", 32'(pkt_valid_o), 32'd0);
    check("p7_accept_no_pop", pops - pops_mark, 32'd0);
    tick();
    check("p8_resume_pop", pops - pops_mark, 32'd1);
    tick();
    check_sum("p8", 2, 8'h19, 0, 8);
    tick();

    // Enable pause mid-packet
    fifo_q.push_back(9'h003);
    fifo_q.push_back(9'h004);
    fifo_q.push_back(9'h105);
    tick();
    tick();
    pops_mark = pops;
    enable_i = 1'b0;
    #1;
    check("pause_grant_now", 32'(fifo_grant_o), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("pause_pops", pops - pops_mark, 32'd0);
    check("pause_no_valid", 32'(pkt_valid_o), 32'd0);
    enable_i = 1'b1;
    wait_pkt("p9");
    check_sum("p9", 3, 8'h0C, 0, 9);
    tick();

    // Asynchronous reset mid-packet
    fifo_q.push_back(9'h007);
    fifo_q.push_back(9'h008);
    fifo_q.push_back(9'h109);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("arst_len",   32'(pkt_len_o),   32'd0);
    check("arst_sum",   32'(pkt_sum_o),   32'd0);
    check("arst_cnt",   32'(pkt_cnt_o),   32'd0);
    check("arst_valid", 32'(pkt_valid_o), 32'd0);
    check("arst_grant", 32'(fifo_grant_o), 32'd0);
    fifo_q.delete();
    tick();
    rst = 1'b0;
    fifo_q.push_back(9'h011);
    fifo_q.push_back(9'h122);
    sum_mark = 8'h33;
    wait_pkt("p10");
    check_sum("p10", 2, 32'(sum_mark), 0, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
